// File: rtl/busnto1.sv
// busnto1: round-robin N-master to 1-slave arbiter for the valid/ready memory bus.
// Optional slave watchdog enabled by defining BUSNTO1_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, grant = 0, arbitrating among m_valid
// BUSY  | one master owns the slave until completion, abandon or abort
module busnto1 #(
    parameter int N_MASTERS      = 4,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [N_MASTERS-1:0]        m_valid,
    output logic [N_MASTERS-1:0]        m_ready,
    input  logic [N_MASTERS*AW-1:0]     m_addr,
    input  logic [N_MASTERS*DW-1:0]     m_wdata,
    input  logic [N_MASTERS*(DW/8)-1:0] m_wstrb,
    output logic [N_MASTERS*DW-1:0]     m_rdata,
    output logic                        s_valid,
    output logic [AW-1:0]               s_addr,
    output logic [DW-1:0]               s_wdata,
    output logic [DW/8-1:0]             s_wstrb,
    input  logic                        s_ready,
    input  logic [DW-1:0]               s_rdata,
    output logic [N_MASTERS-1:0]        grant,
    output logic                        timeout
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_chk_n
        $error("busnto1: N_MASTERS must be in 2..8");
    end
    if (DW % 8 != 0) begin : g_chk_dw
        $error("busnto1: DW must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_chk_to
        $error("busnto1: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        ptr_next;
    logic [IW-1:0]        win_lo, win_hi, win_idx;
    logic                 hi_found;
    logic                 sel_valid;
    logic                 abort;

    assign grant     = grant_q;
    assign sel_valid = |(m_valid & grant_q);
    assign ptr_next  = (gidx_q == IW'(N_MASTERS - 1)) ? '0 : gidx_q + 1'b1;

`ifdef BUSNTO1_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            wd_cnt_q <= '0;
        end else if (s_valid && !s_ready) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // A late s_ready in the would-be abort cycle still completes normally.
    assign abort = (state_q == ST_BUSY) && sel_valid && !s_ready &&
                   (wd_cnt_q == WW'(TIMEOUT_CYCLES));
`else
    assign abort = 1'b0;
`endif

    // Lowest requester at or above rr_ptr wins, else the lowest requester overall.
    always_comb begin
        win_lo   = '0;
        win_hi   = '0;
        hi_found = 1'b0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_valid[i]) begin
                win_lo = IW'(i);
                if (IW'(i) >= rr_ptr_q) begin
                    win_hi   = IW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        win_idx = hi_found ? win_hi : win_lo;
    end

    // grant_q is zero while idle, so every slice below falls back to zero.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;
        m_rdata = '0;
        m_ready = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_addr                = m_addr[i*AW +: AW];
                s_wdata               = m_wdata[i*DW +: DW];
                s_wstrb               = m_wstrb[i*SW +: SW];
                m_rdata[i*DW +: DW]   = abort ? {DW{1'b1}} : s_rdata;
                m_ready[i]            = sel_valid && (s_ready || abort);
            end
        end
        s_valid = sel_valid && !abort;
        timeout = abort;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_valid) begin
                    state_d          = ST_BUSY;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                end
            end
            ST_BUSY: begin
                if (!sel_valid || s_ready || abort) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ptr_next;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_busnto1.sv
// Bench for busnto1: directed bus scenarios checked against a transaction-level
// model every cycle, plus literal expectations taken from the bus scenarios.
module tb_busnto1;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;
`ifdef BUSNTO1_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    m_valid;
    logic [N-1:0]    m_ready;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N*DW-1:0] m_rdata;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_ready;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    grant;
    logic            timeout;

    busnto1 #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner index (-1 = nobody), round-robin pointer, wait count.
    int mo_owner = -1, mo_ptr = 0, mo_wd = 0;
    int nx_owner = -1, nx_ptr = 0, nx_wd = 0;
    int cand, o;
    logic            mv, ab;
    logic [N-1:0]    e_grant, e_mready;
    logic            e_sv, e_to;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [SW-1:0]   e_wstrb;
    logic [N*DW-1:0] e_rdata;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mo_owner = -1; mo_ptr = 0; mo_wd = 0;
        end else begin
            mo_owner = nx_owner; mo_ptr = nx_ptr; mo_wd = nx_wd;
        end
    end

    always @(negedge clk) begin
        e_grant = '0; e_mready = '0; e_sv = 1'b0; e_to = 1'b0;
        e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rdata = '0;
        nx_owner = mo_owner; nx_ptr = mo_ptr; nx_wd = mo_wd;
        if (!resetn) begin
            nx_owner = -1; nx_ptr = 0; nx_wd = 0;
        end else if (mo_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                cand = (mo_ptr + k) % N;
                if (m_valid[cand] && nx_owner < 0) begin
                    nx_owner = cand;
                    nx_wd    = 0;
                end
            end
        end else begin
            o  = mo_owner;
            mv = m_valid[o];
            ab = TO_EN && mv && !s_ready && (mo_wd == TO);
            e_grant  = N'(1 << o);
            e_sv     = mv && !ab;
            e_addr   = m_addr[o*AW +: AW];
            e_wdata  = m_wdata[o*DW +: DW];
            e_wstrb  = m_wstrb[o*SW +: SW];
            e_mready = (mv && (s_ready || ab)) ? N'(1 << o) : '0;
            e_rdata[o*DW +: DW] = ab ? {DW{1'b1}} : s_rdata;
            e_to     = ab;
            if (!mv || s_ready || ab) begin
                nx_owner = -1;
                nx_ptr   = (o + 1) % N;
            end else begin
                nx_wd = mo_wd + 1;
            end
        end
        check("grant",   grant,   e_grant);
        check("s_valid", s_valid, e_sv);
        check("s_addr",  s_addr,  e_addr);
        check("s_wdata", s_wdata, e_wdata);
        check("s_wstrb", s_wstrb, e_wstrb);
        check("m_ready", m_ready, e_mready);
        check("m_rdata", m_rdata, e_rdata);
        check("timeout", timeout, e_to);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    int order[$];
    logic [N-1:0] prev_g;
    int pulses, sv_cnt, to_cnt;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        resetn  = 1'b0;
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready = 1'b0; s_rdata = '0;
        obs();
        check("reset grant",   grant,   4'b0000);
        check("reset s_valid", s_valid, 1'b0);
        check("reset timeout", timeout, 1'b0);
        tick();
        resetn = 1'b1;
        tick();

        // Round robin: all masters requesting, zero-wait slave.
        m_valid = 4'hF;
        for (int i = 0; i < N; i++) m_addr[i*AW +: AW] = 32'h1000 + 32'(i);
        s_ready = 1'b1;
        s_rdata = 32'h0BADBEEF;
        prev_g  = '0;
        for (int c = 0; c < 10; c++) begin
            obs();
            if (grant != 0 && prev_g == 0) begin
                for (int i = 0; i < N; i++) if (grant[i]) order.push_back(i);
            end
            prev_g = grant;
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        check("rr count", order.size(), 5);
        if (order.size() == 5) begin
            check("rr 0", order[0], 0);
            check("rr 1", order[1], 1);
            check("rr 2", order[2], 2);
            check("rr 3", order[3], 3);
            check("rr 4", order[4], 0);
        end

        // Single read by master 2, zero-wait slave.
        tick();
        m_addr  = '0;
        m_addr[2*AW +: AW] = 32'h100;
        m_valid = 4'b0100;
        s_ready = 1'b1;
        s_rdata = 32'hCAFEF00D;
        obs();
        check("rd c0 s_valid", s_valid, 1'b0);
        tick();
        obs();
        check("rd c1 s_valid", s_valid, 1'b1);
        check("rd c1 s_addr",  s_addr,  32'h100);
        check("rd c1 m_ready", m_ready, 4'b0100);
        check("rd c1 m_rdata", m_rdata[2*DW +: DW], 32'hCAFEF00D);
        tick();
        m_valid = '0;
        obs();
        check("rd c2 grant", grant, 4'b0000);

        // Write by master 1 with three wait states.
        tick();
        s_ready = 1'b0;
        m_addr[1*AW +: AW]  = 32'h200;
        m_wdata[1*DW +: DW] = 32'h12345678;
        m_wstrb[1*SW +: SW] = 4'b0011;
        m_valid = 4'b0010;
        pulses  = 0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) s_ready = 1'b1;
            obs();
            check("wr grant",   grant,   4'b0010);
            check("wr s_wdata", s_wdata, 32'h12345678);
            check("wr s_wstrb", s_wstrb, 4'b0011);
            if (m_ready[1]) pulses++;
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        m_wstrb = '0;
        obs();
        check("wr pulses", pulses, 1);
        check("wr idle",   grant,  4'b0000);

        // Abandon by master 0, then masters 0 and 1 show where the pointer went.
        tick();
        m_valid = 4'b0001;
        tick();
        obs();
        check("ab grant", grant, 4'b0001);
        tick();
        tick();
        m_valid = 4'b0000;
        obs();
        check("ab m_ready", m_ready, 4'b0000);
        tick();
        m_valid = 4'b0011;
        obs();
        check("ab idle", grant, 4'b0000);
        tick();
        s_ready = 1'b1;
        obs();
        check("ab next grant", grant, 4'b0010);
        tick();
        m_valid = 4'b0001;
        tick();
        obs();
        check("ab m0 grant", grant, 4'b0001);
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();

        // Master 3 read against a slave that stalls.
        m_valid = 4'b1000;
        m_addr[3*AW +: AW] = 32'h300;
        sv_cnt = 0; to_cnt = 0; pulses = 0;
        tick();
`ifdef BUSNTO1_TIMEOUT_EN
        for (int c = 1; c <= 6; c++) begin
            obs();
            if (s_valid) sv_cnt++;
            if (timeout) to_cnt++;
            if (m_ready[3]) pulses++;
            if (c == 5) begin
                check("to c5 timeout", timeout, 1'b1);
                check("to c5 m_ready", m_ready, 4'b1000);
                check("to c5 m_rdata", m_rdata[3*DW +: DW], 32'hFFFFFFFF);
            end
            tick();
            if (c == 5) m_valid = '0;
        end
        check("to s_valid cycles", sv_cnt, 4);
        check("to pulses",         to_cnt, 1);
        check("to m_ready pulses", pulses, 1);
`else
        for (int c = 1; c <= 8; c++) begin
            obs();
            if (s_valid) sv_cnt++;
            if (timeout) to_cnt++;
            tick();
        end
        s_ready = 1'b1;
        s_rdata = 32'h5A5A1234;
        obs();
        check("wait m_ready", m_ready, 4'b1000);
        check("wait m_rdata", m_rdata[3*DW +: DW], 32'h5A5A1234);
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        check("wait s_valid cycles", sv_cnt, 8);
        check("wait no timeout",     to_cnt, 0);
`endif
        tick();

        // Async reset in the middle of a transaction by master 2.
        m_valid = 4'b0010;
        s_ready = 1'b1;
        tick();
        tick();
        m_valid = 4'b0100;
        s_ready = 1'b0;
        tick();
        @(posedge clk);
        #1 s_ready = 1'b1;
        #1 check("rst pre m_ready", m_ready, 4'b0100);
        resetn = 1'b0;
        #1;
        check("rst grant",   grant,   4'b0000);
        check("rst s_valid", s_valid, 1'b0);
        check("rst m_ready", m_ready, 4'b0000);
        s_ready = 1'b0;
        tick();
        tick();
        resetn  = 1'b1;
        m_valid = 4'b0101;
        s_ready = 1'b1;
        obs();
        check("rel idle", grant, 4'b0000);
        tick();
        obs();
        check("rel grant", grant, 4'b0001);
        tick();
        m_valid = 4'b0100;
        tick();
        obs();
        check("rel m2 grant", grant, 4'b0100);
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
